// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   B_INS            : RV32 conditional-branch opcode
//   fetch_state_e    : fetch sequencer states
//   BHT_SIZE_LOG_DEF : default log2 of the branch history table depth
package ins_fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned OPC_W            = 7;
  localparam int unsigned BHT_SIZE_LOG_DEF = 6;

  localparam logic [OPC_W-1:0] B_INS = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // True when the word is a conditional branch (the only class we predict).
  function automatic logic is_branch(input logic [XLEN-1:0] word);
    return word[OPC_W-1:0] == B_INS;
  endfunction

endpackage

// File: rtl/ins_fetch_branch_predictor.sv
// Branch history table of 2-bit saturating counters.
// Ports:
//   clk_in, rst_in, rdy_in : clock, sync active-high reset, global enable
//   i_rd_pc / o_taken_c    : combinational lookup, predict = counter msb
//   i_upd_valid/_pc/_taken : commit-time training port
// A lookup and update of the same entry in one cycle returns the old value.
module branch_predictor
  import ins_fetch_pkg::*;
#(
  parameter int unsigned BHT_SIZE_LOG = BHT_SIZE_LOG_DEF
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic [XLEN-1:0] i_rd_pc,
  output logic            o_taken_c,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken
);

  localparam int unsigned DEPTH = 1 << BHT_SIZE_LOG;

  logic [1:0]              r_cnt [DEPTH];
  logic [BHT_SIZE_LOG-1:0] w_rd_idx;
  logic [BHT_SIZE_LOG-1:0] w_upd_idx;
  logic                    w_unused;

  // Word-aligned PCs: drop the two byte-offset bits.
  assign w_rd_idx  = i_rd_pc[BHT_SIZE_LOG+1:2];
  assign w_upd_idx = i_upd_pc[BHT_SIZE_LOG+1:2];
  assign w_unused  = ^{i_rd_pc[XLEN-1:BHT_SIZE_LOG+2], i_rd_pc[1:0],
                       i_upd_pc[XLEN-1:BHT_SIZE_LOG+2], i_upd_pc[1:0]};

  // Counter array with saturating train.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_cnt[i] <= 2'b01;
    end else if (rdy_in && i_upd_valid) begin
      if (i_upd_taken) begin
        if (r_cnt[w_upd_idx] != 2'b11) r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + 2'd1;
      end else begin
        if (r_cnt[w_upd_idx] != 2'b00) r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - 2'd1;
      end
    end
  end

  assign o_taken_c = r_cnt[w_rd_idx][1];

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: one outstanding memory read, presents the word to
// the decoder with its PC and a taken prediction, redirects on RoB flush.
// Build option: define BHT_EN to build the branch history table; otherwise
// isjump is constant 0 and rob_br_* are ignored.
// Ports:
//   clk_in, rst_in, rdy_in           : clock, sync active-high reset, enable
//   if_valid, instr, pc, isjump      : registered decoder-facing outputs
//   stall, dc_valid, dc_nextpc       : decoder handshake / next PC
//   rob_clear, rob_newpc             : flush and redirect target
//   rob_br_valid/_pc/_taken          : committed branch outcome (BHT training)
//   mem_if_req/_addr, mem_if_ready/_data : memory controller fetch port
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int unsigned     BHT_SIZE_LOG = BHT_SIZE_LOG_DEF,
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  output logic            if_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            isjump,
  input  logic            stall,
  input  logic            dc_valid,
  input  logic [XLEN-1:0] dc_nextpc,
  input  logic            rob_clear,
  input  logic [XLEN-1:0] rob_newpc,
  input  logic            rob_br_valid,
  input  logic [XLEN-1:0] rob_br_pc,
  input  logic            rob_br_taken,
  output logic            mem_if_req,
  output logic [XLEN-1:0] mem_if_addr,
  input  logic            mem_if_ready,
  input  logic [XLEN-1:0] mem_if_data
);

  fetch_state_e    r_state,    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic            r_if_valid, w_if_valid_nxt;
  logic [XLEN-1:0] r_instr,    w_instr_nxt;
  logic [XLEN-1:0] r_pc,       w_pc_nxt;
  logic            r_isjump,   w_isjump_nxt;
  logic            r_req,      w_req_nxt;
  logic [XLEN-1:0] r_addr,     w_addr_nxt;
  logic            w_predict;
  logic            w_unused_stall;

  // Backpressure is already folded into dc_valid by the decoder.
  assign w_unused_stall = stall;

`ifdef BHT_EN
  branch_predictor #(
    .BHT_SIZE_LOG (BHT_SIZE_LOG)
  ) u_bht (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .i_rd_pc     (r_fetch_pc),
    .o_taken_c   (w_predict),
    .i_upd_valid (rob_br_valid),
    .i_upd_pc    (rob_br_pc),
    .i_upd_taken (rob_br_taken)
  );
`else
  logic w_unused_bht;
  assign w_predict    = 1'b0;
  assign w_unused_bht = ^{rob_br_valid, rob_br_pc, rob_br_taken, 1'(BHT_SIZE_LOG)};
`endif

  // Next-state and next-output logic; flush outranks every other event.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_if_valid_nxt = r_if_valid;
    w_instr_nxt    = r_instr;
    w_pc_nxt       = r_pc;
    w_isjump_nxt   = r_isjump;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;

    if (rob_clear) begin
      w_fetch_pc_nxt = rob_newpc;
      w_if_valid_nxt = 1'b0;
      w_req_nxt      = 1'b0;
      // A read still in flight must be swallowed before the next issue.
      if (r_state == ST_DRAIN) begin
        w_state_nxt = mem_if_ready ? ST_IDLE : ST_DRAIN;
      end else if (r_state == ST_WAIT && !mem_if_ready) begin
        w_state_nxt = ST_DRAIN;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_if_ready) begin
            w_instr_nxt    = mem_if_data;
            w_pc_nxt       = r_fetch_pc;
            w_if_valid_nxt = 1'b1;
            w_req_nxt      = 1'b0;
            w_isjump_nxt   = is_branch(mem_if_data) && w_predict;
            w_state_nxt    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (dc_valid) begin
            w_if_valid_nxt = 1'b0;
            w_fetch_pc_nxt = dc_nextpc;
            w_req_nxt      = 1'b1;
            w_addr_nxt     = dc_nextpc;
            w_state_nxt    = ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (mem_if_ready) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_if_valid <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_isjump   <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= '0;
    end else if (rdy_in) begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_instr    <= w_instr_nxt;
      r_pc       <= w_pc_nxt;
      r_isjump   <= w_isjump_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  assign if_valid    = r_if_valid;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign isjump      = r_isjump;
  assign mem_if_req  = r_req;
  assign mem_if_addr = r_addr;

endmodule
